// File: rtl/dp_mem_bist_pkg.sv
// dp_mem_bist_pkg: FSM states, phase codes and test patterns shared by the dual-port RAM BIST.
package dp_mem_bist_pkg;
  typedef enum logic [3:0] {
    IDLE, M0_W, M_RD, M_WR, M5_RD, M5_CHK, CF_WR, CF_FLAG, CF_CHK, DONE
  } state_t;
  localparam logic [2:0] PH_0 = 3'd0;
  localparam logic [2:0] PH_1 = 3'd1;
  localparam logic [2:0] PH_2 = 3'd2;
  localparam logic [2:0] PH_3 = 3'd3;
  localparam logic [2:0] PH_4 = 3'd4;
  localparam logic [2:0] PH_5 = 3'd5;
  localparam logic [2:0] PH_6 = 3'd6;
  localparam int PAT_MAX = 64;
  function automatic logic [PAT_MAX-1:0] pat_z();
    return '0;
  endfunction
  function automatic logic [PAT_MAX-1:0] pat_o();
    return '1;
  endfunction
  function automatic logic [PAT_MAX-1:0] pat_p();
    return {32{2'b01}};
  endfunction
endpackage

// File: rtl/dp_mem_bist_addr_gen.sv
// dp_mem_bist_addr_gen: loadable up/down address counter with terminal-count flag.
module dp_mem_bist_addr_gen
  import dp_mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  load_up,
  input  logic                  step,
  input  logic                  up,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  tc
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) addr <= '0;
    else if (load) addr <= load_up ? '0 : LAST;
    else if (step) addr <= up ? addr + 1'b1 : addr - 1'b1;
  assign tc = up ? addr == LAST : addr == '0;
endmodule

// File: rtl/dp_mem_bist.sv
// dp_mem_bist: March C- BIST for the dual-port RAM, plus same-address write conflict check
// when BIST_CONFLICT_CHECK_EN is defined.
module dp_mem_bist
  import dp_mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_phase,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_in_a,
  output logic [DATA_WIDTH-1:0] data_in_b,
  output logic                  write_en_a,
  output logic                  write_en_b,
  output logic                  read_en_a,
  output logic                  read_en_b,
  input  logic [DATA_WIDTH-1:0] data_out_a,
  input  logic [DATA_WIDTH-1:0] data_out_b,
  input  logic                  conflict_flag
);
  localparam logic [DATA_WIDTH-1:0] PZ = DATA_WIDTH'(pat_z());
  localparam logic [DATA_WIDTH-1:0] PO = DATA_WIDTH'(pat_o());
  localparam logic [DATA_WIDTH-1:0] PP = DATA_WIDTH'(pat_p());
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  state_t                  state;
  logic [2:0]              phase;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    tc, port_b, adv, load, load_up, step, mis_a, mis_b;
  logic [DATA_WIDTH-1:0]   exp_d;
  logic [8:0]              fc_sum;
  logic [7:0]              fc_next;
  assign port_b  = phase == PH_3 || phase == PH_4;
  assign exp_d   = (phase == PH_2 || phase == PH_4) ? PO : PZ;
  assign adv     = state == M0_W || state == M_WR || state == M5_CHK;
  assign load    = (state == IDLE && start) || (adv && tc);
  assign load_up = !(state == M_WR && (phase == PH_2 || phase == PH_3));
  assign step    = adv && !tc;
  dp_mem_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_addr_gen (
    .clk(clk), .reset_n(reset_n), .load(load), .load_up(load_up), .step(step),
    .up(!port_b), .addr(cnt), .tc(tc)
  );
  assign mis_a = (state == M_WR && !port_b && data_out_a != exp_d) ||
                 (state == M5_CHK && data_out_a != PZ);
`ifdef BIST_CONFLICT_CHECK_EN
  assign mis_b = (state == M_WR && port_b && data_out_b != exp_d) ||
                 (state == M5_CHK && data_out_b != PZ) ||
                 (state == CF_FLAG && !conflict_flag) ||
                 (state == CF_CHK && data_out_b != PP);
`else
  logic unused_cf;
  assign unused_cf = conflict_flag;
  assign mis_b = (state == M_WR && port_b && data_out_b != exp_d) ||
                 (state == M5_CHK && data_out_b != PZ);
`endif
  assign fc_sum  = {1'b0, fail_count} + 9'(mis_a) + 9'(mis_b);
  assign fc_next = fc_sum[8] ? 8'hff : fc_sum[7:0];
  assign busy       = state != IDLE && state != DONE;
  assign addr_a     = (state inside {M0_W, M5_RD, M5_CHK} || (state inside {M_RD, M_WR} && !port_b)) ? cnt : '0;
  assign addr_b     = state inside {M5_RD, M5_CHK} ? LAST - cnt : (state inside {M_RD, M_WR} && port_b) ? cnt : '0;
  assign read_en_a  = state == M5_RD || (state == M_RD && !port_b);
  assign read_en_b  = state == M5_RD || (state == M_RD && port_b) || state == CF_FLAG;
  assign write_en_a = state == M0_W || (state == M_WR && !port_b) || state == CF_WR;
  assign write_en_b = (state == M_WR && port_b) || state == CF_WR;
  assign data_in_a  = state == CF_WR ? PP : (state == M_WR && !port_b) ? ~exp_d : PZ;
  assign data_in_b  = state == CF_WR ? ~PP : (state == M_WR && port_b) ? ~exp_d : PZ;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= PH_0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      fail_addr  <= '0;
      fail_phase <= '0;
    end else begin
      fail_count <= fc_next;
      done       <= 1'b0;
      if ((mis_a || mis_b) && fail_count == 8'd0) begin
        fail_addr  <= cnt;
        fail_phase <= phase;
      end
      case (state)
        IDLE: if (start) begin
          state      <= M0_W;
          phase      <= PH_0;
          pass       <= 1'b0;
          fail_count <= '0;
          fail_addr  <= '0;
          fail_phase <= '0;
        end
        M0_W: if (tc) begin
          state <= M_RD;
          phase <= PH_1;
        end
        M_RD: state <= M_WR;
        M_WR: begin
          state <= (tc && phase == PH_4) ? M5_RD : M_RD;
          if (tc) phase <= phase + 3'd1;
        end
        M5_RD: state <= M5_CHK;
`ifdef BIST_CONFLICT_CHECK_EN
        M5_CHK: if (tc) begin
          state <= CF_WR;
          phase <= PH_6;
        end else state <= M5_RD;
        CF_WR:   state <= CF_FLAG;
        CF_FLAG: state <= CF_CHK;
        CF_CHK: begin
          state <= DONE;
          done  <= 1'b1;
          pass  <= fc_next == 8'd0;
        end
`else
        M5_CHK: if (tc) begin
          state <= DONE;
          done  <= 1'b1;
          pass  <= fc_next == 8'd0;
        end else state <= M5_RD;
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/dp_mem_bist.md
# dp_mem_bist

Built-in self-test engine for the team's synchronous dual-port RAM (`sync_dual_port_ram`). It is the initiator side of that RAM interface. It drives both ports through a March C- sequence, then exercises a same-address write conflict. It checks every read against the expected pattern and reports pass/fail with the first failing address and phase. It sits between the system control logic and a dual-port RAM instance, muxed onto the RAM ports during test.

## Interface
Reset: one clock; reset is asynchronous and active-low.

Parameters:
- DATA_WIDTH, 8, RAM data width
- ADDR_WIDTH, 4, RAM address width
- MEM_DEPTH, 1<<ADDR_WIDTH, words tested (D); 2 ≤ D ≤ 2^ADDR_WIDTH

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled in IDLE only
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at completion
- pass  out  1  result, valid from done until next start
- fail_count  out  8  mismatches, saturating at 255
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_phase  out  3  phase of first mismatch (0–6)
- addr_a, addr_b  out  ADDR_WIDTH  RAM addresses
- data_in_a, data_in_b  out  DATA_WIDTH  RAM write data
- write_en_a, write_en_b, read_en_a, read_en_b  out  1  RAM strobes
- data_out_a, data_out_b  in  DATA_WIDTH  RAM read data
- conflict_flag  in  1  RAM same-address write conflict indicator

## Operation
- Pattern definitions:
  - Z = all zeros.
  - O = all ones.
  - P = alternating 0101… (0x55 at width 8).
  - ~P = its inverse.
- IDLE: all RAM strobes 0. Addresses and write data are 0.
  - When start=1: clear fail_count, fail_addr, fail_phase and pass, then enter phase 0.
- Phases and port use:
  - 0: ascending, write Z, port A.
  - 1: ascending, read Z then write O, port A.
  - 2: ascending, read O then write Z, port A.
  - 3: descending (D-1 → 0), read Z then write O, port B.
  - 4: descending, read O then write Z, port B.
  - 5: ascending reads on A with simultaneous descending reads on B, both expecting Z.
  - 6: conflict check.
- Read/modify element, 2 cycles per address:
  - RD state: assert read_en.
  - WR state: compare data_out to the expected value and assert write_en with the new pattern.
- Phase 5, 2 cycles per address:
  - RD state: both read_en asserted.
  - CHK state: compare both ports.
  - A mismatch on both ports at one address counts 2. fail_addr records the port A address.
- Phase 6 (only with macro), 3 cycles:
  - CF_WR: addr_a = addr_b = 0; write P on A and ~P on B simultaneously.
  - CF_FLAG: require conflict_flag=1, otherwise count a fail at address 0. Issue read_en_b at address 0.
  - CF_CHK: require data_out_b == P (port A priority).
- Mismatch handling:
  - Increment fail_count, saturating at 255.
  - On the first mismatch only, latch fail_addr and fail_phase.
- Completion:
  - Enter DONE; pulse done for 1 cycle with pass = (fail_count==0).
  - Return to IDLE. Results hold until the next start.
- start while busy is ignored. start held high re-triggers only after DONE→IDLE.
- Address counter rules:
  - Up-count terminates at D-1; down-count terminates at 0. No wrap is issued.
  - The counter reloads at each phase boundary.

## Timing
- Reset values: all outputs 0, state IDLE.
- reset_n low mid-run: immediate return to IDLE with all strobes 0. The run is abandoned; there is no partial result.
- RAM read latency is fixed at 1 cycle. Data is sampled in the cycle after read_en.
- busy rises the cycle after start is sampled. It stays high exactly 11·D+3 cycles (11·D without macro); D=16 gives 179.
- done is high in the cycle after busy falls.
- Only one write strobe is active per port per cycle. Port B is idle in phases 0–2; port A is idle in phases 3–4.

## Configuration
- BIST_CONFLICT_CHECK_EN defined:
  - Phase 6 is included.
  - conflict_flag is checked.
  - Run length is 11·D+3.
- Not defined:
  - Phase 6 states are absent and conflict_flag is ignored.
  - DONE follows phase 5; run length is 11·D.

## Structure
- Package dp_mem_bist_pkg holds:
  - state enum: IDLE, M0_W, M_RD, M_WR, M5_RD, M5_CHK, CF_WR, CF_FLAG, CF_CHK, DONE;
  - phase code constants 0–6;
  - pattern functions Z/O/P sized by width.
- Sub-module dp_mem_bist_addr_gen: loadable up/down address counter with a terminal-count flag. The top level holds the FSM, compare and result registers.

## Test plan
- Fault-free behavioural RAM, D=16, macro on, start pulse → busy 179 cycles, done pulse, pass=1, fail_count=0.
- Model with bit 3 of address 5 stuck-at-0 → pass=0, fail_addr=5, fail_phase=2, fail_count=2.
- Model ignoring port B writes → fail_addr=15, fail_phase=4, fail_count=16.
- conflict_flag tied 0, macro on → pass=0, fail_phase=6, fail_addr=0, fail_count=1.
- Same conflict_flag tie-off, macro off → pass=1, busy 176 cycles.
- reset_n pulsed low during phase 2 → all outputs 0 and strobes 0 immediately; a new start then gives a clean full run with pass=1.
- start held high 5 cycles and re-pulsed mid-run → exactly one run until DONE. The mid-run pulse has no effect on busy length.
